// File: rtl/pyc_rr_stream_arbiter.sv
// Purpose : N-to-1 round-robin arbiter for ready/valid packet streams; packets are never interleaved.
// Latency : one arbitration cycle per packet, then a beat accepted at edge t is on out_* from cycle t+1.
// Backpress: in_ready of the granted requester follows output-slot availability; in_ready never depends on in_valid.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        per-requester handshake (N bits each)
//   in_data                  requester i at bits [i*WIDTH +: WIDTH]
//   in_last                  per-requester end-of-packet
//   out_valid/out_ready      output handshake (out_valid registered)
//   out_data/out_last/out_src registered output beat, its end-of-packet flag and source index
module pyc_rr_stream_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [SW-1:0]      out_src
);

    if (N < 1 || WIDTH < 1) begin : g_bad_param
        $error("ERROR: pyc_rr_stream_arbiter needs N>=1 and WIDTH>=1");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    grant_q, grant_d;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [SW-1:0]    out_src_q, out_src_d;

    logic             slot_free;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             accept;
    logic             found;
    logic [SW-1:0]    pick;

    always_comb begin
        // Output register can take a new beat when empty or being drained this cycle.
        slot_free = ~out_valid_q | out_ready;

        sel_valid = 1'b0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == SW'(i)) begin
                sel_valid = in_valid[i];
                sel_data  = in_data[i*WIDTH +: WIDTH];
                sel_last  = in_last[i];
            end
        end

        for (int i = 0; i < N; i++) begin
            in_ready[i] = (state_q == BUSY) && (grant_q == SW'(i)) && slot_free;
        end

        accept = (state_q == BUSY) && slot_free && sel_valid;

        // Rotating priority: first pass covers ptr..N-1, second pass wraps to 0..ptr-1.
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && in_valid[i] && (SW'(i) >= ptr_q)) begin
                found = 1'b1;
                pick  = SW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && in_valid[i]) begin
                found = 1'b1;
                pick  = SW'(i);
            end
        end

        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && sel_last) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == SW'(N - 1)) ? '0 : grant_q + SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_src_d   = grant_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_pyc_rr_stream_arbiter.sv
// Purpose : directed bench for pyc_rr_stream_arbiter (N=4, WIDTH=8).
// Latency : inputs driven 1ns after each rising edge, outputs sampled there too.
// Backpress: exercises held out_ready low mid-packet.
module tb_pyc_rr_stream_arbiter;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SW    = 2;

    logic               clk;
    logic               rst;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_last;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic [SW-1:0]      out_src;

    int n_vec;
    int n_bad;

    pyc_rr_stream_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int i, input logic [7:0] d, input logic l);
        in_data[i*WIDTH +: WIDTH] = d;
        in_last[i] = l;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                             input logic l, input logic [1:0] s);
        check_val({tag, ".valid"}, 32'(out_valid), 32'(v));
        check_val({tag, ".data"},  32'(out_data),  32'(d));
        check_val({tag, ".last"},  32'(out_last),  32'(l));
        check_val({tag, ".src"},   32'(out_src),   32'(s));
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 4'hF;
        in_data   = 32'h0403_0201;
        in_last   = 4'hF;
        out_ready = 1'b1;

        // 1: reset with every requester valid
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("rst.in_ready",  32'(in_ready),  32'h0);
            check_val("rst.out_valid", 32'(out_valid), 32'h0);
            check_val("rst.out_src",   32'(out_src),   32'h0);
        end
        rst      = 1'b0;
        in_valid = 4'h0;
        tick();
        check_val("post_rst.out_valid", 32'(out_valid), 32'h0);

        // 2: req2 alone, 3-beat packet
        in_valid = 4'b0100;
        set_beat(2, 8'hA1, 1'b0);
        tick();                                   // arbitration edge
        check_val("p2.arb_valid", 32'(out_valid), 32'h0);
        check_val("p2.in_ready",  32'(in_ready),  32'b0100);
        tick();
        check_out("p2.A", 1'b1, 8'hA1, 1'b0, 2'd2);
        set_beat(2, 8'hB2, 1'b0);
        tick();
        check_out("p2.B", 1'b1, 8'hB2, 1'b0, 2'd2);
        set_beat(2, 8'hC3, 1'b1);
        tick();
        check_out("p2.C", 1'b1, 8'hC3, 1'b1, 2'd2);
        check_val("p2.idle_ready", 32'(in_ready), 32'h0);
        in_valid = 4'h0;
        tick();
        check_val("p2.drain", 32'(out_valid), 32'h0);

        // 3: all requesters, single-beat packets; ptr=3 so order is 3,0,1,2,3
        for (int i = 0; i < N; i++) set_beat(i, 8'(8'h10 + i), 1'b1);
        in_valid = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k % 2 == 1) begin
                check_out($sformatf("rr%0d", k), 1'b1, 8'(8'h10 + ((3 + k / 2) % 4)),
                          1'b1, 2'((3 + k / 2) % 4));
            end else begin
                check_val($sformatf("rr%0d.bubble", k), 32'(out_valid), 32'h0);
            end
        end
        in_valid = 4'h0;
        tick();                                   // ptr now 0

        // 4: req0 packet is not interrupted by req1
        in_valid = 4'b0011;
        set_beat(0, 8'h20, 1'b0);
        set_beat(1, 8'h30, 1'b1);
        tick();
        check_val("p4.grant0", 32'(in_ready), 32'b0001);
        tick();
        check_out("p4.b0", 1'b1, 8'h20, 1'b0, 2'd0);
        set_beat(0, 8'h21, 1'b0);
        tick();
        check_out("p4.b1", 1'b1, 8'h21, 1'b0, 2'd0);
        set_beat(0, 8'h22, 1'b1);
        tick();
        check_out("p4.b2", 1'b1, 8'h22, 1'b1, 2'd0);
        set_beat(0, 8'h23, 1'b1);                 // req0 immediately requests again
        tick();
        check_val("p4.grant1", 32'(in_ready), 32'b0010);
        tick();
        check_out("p4.r1", 1'b1, 8'h30, 1'b1, 2'd1);
        in_valid = 4'b0001;
        tick();
        tick();
        check_out("p4.r0again", 1'b1, 8'h23, 1'b1, 2'd0);
        in_valid = 4'h0;
        tick();                                   // ptr now 1

        // 5: backpressure mid-packet from req1
        in_valid = 4'b0010;
        set_beat(1, 8'h40, 1'b0);
        tick();
        tick();
        check_out("p5.b0", 1'b1, 8'h40, 1'b0, 2'd1);
        set_beat(1, 8'h41, 1'b0);
        out_ready = 1'b0;
        #1;
        check_val("p5.stall_ready", 32'(in_ready), 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out($sformatf("p5.hold%0d", k), 1'b1, 8'h40, 1'b0, 2'd1);
            check_val($sformatf("p5.hold%0d.rdy", k), 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check_val("p5.resume_ready", 32'(in_ready), 32'b0010);
        tick();
        check_out("p5.b1", 1'b1, 8'h41, 1'b0, 2'd1);
        set_beat(1, 8'h42, 1'b0);
        tick();
        check_out("p5.b2", 1'b1, 8'h42, 1'b0, 2'd1);
        set_beat(1, 8'h43, 1'b1);
        tick();
        check_out("p5.b3", 1'b1, 8'h43, 1'b1, 2'd1);
        in_valid = 4'h0;
        tick();
        check_val("p5.drain", 32'(out_valid), 32'h0);  // ptr now 2

        // 6: reset in the middle of a req3 packet
        in_valid = 4'b1000;
        set_beat(3, 8'h50, 1'b0);
        tick();
        tick();
        check_out("p6.b0", 1'b1, 8'h50, 1'b0, 2'd3);
        rst = 1'b1;
        set_beat(3, 8'h51, 1'b0);
        tick();
        check_out("p6.rst", 1'b0, 8'h00, 1'b0, 2'd0);
        check_val("p6.rst_ready", 32'(in_ready), 32'h0);
        rst      = 1'b0;
        in_valid = 4'b1010;
        set_beat(1, 8'h60, 1'b1);
        tick();
        check_val("p6.grant1", 32'(in_ready), 32'b0010);
        tick();
        check_out("p6.r1", 1'b1, 8'h60, 1'b1, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
